// File: rtl/udp_packet_buffer.sv
// udp_packet_buffer
//   Store-and-forward buffer between the UDP RX core and the LED frame
//   writer. Payload words arrive without backpressure. Each packet is held
//   until its last word has been written. It is then presented whole on a
//   first-word-fall-through sink, with its destination port (minus
//   PORT_OFFSET) and UDP length. A packet that does not fit is dropped
//   atomically, and no part of it ever reaches the sink.
//
//   Handshake: the source has no ready signal, and a word is taken on every
//   cycle with udp_source_valid=1. On the sink, a word moves on a cycle
//   where udp_sink_valid && udp_sink_ready. While udp_sink_valid is high,
//   the sink holds its word stable. While udp_sink_valid is low, every
//   sink output is 0.
//
// Ports
//   clk, rst (synchronous, active-low)
//   udp_source_{valid,last,dst_port,length,data}  : packet input
//   udp_sink_{ready,valid,last,dst_port,length,data} : FWFT packet output
//   pkt_count   : committed packets not yet fully read
//   drop_pulse  : one-cycle pulse per dropped packet
//   drop_count  : saturating drop counter. It is present only when
//                 UDP_BUF_STATS_EN is defined; otherwise it is tied to 0.
module udp_packet_buffer #(
  parameter int          DATA_WIDTH       = 8,
  parameter int          DEPTH_WIDTH      = 10,
  parameter int          META_DEPTH_WIDTH = 4,
  parameter logic [15:0] PORT_OFFSET      = 16'h0100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        udp_source_valid,
  input  logic                        udp_source_last,
  input  logic [15:0]                 udp_source_dst_port,
  input  logic [15:0]                 udp_source_length,
  input  logic [31:0]                 udp_source_data,
  input  logic                        udp_sink_ready,
  output logic                        udp_sink_valid,
  output logic                        udp_sink_last,
  output logic [15:0]                 udp_sink_dst_port,
  output logic [15:0]                 udp_sink_length,
  output logic [31:0]                 udp_sink_data,
  output logic [META_DEPTH_WIDTH:0]   pkt_count,
  output logic                        drop_pulse,
  output logic [15:0]                 drop_count
);

  localparam int PW  = DEPTH_WIDTH + 1;
  localparam int MPW = META_DEPTH_WIDTH + 1;
  localparam logic [PW-1:0]  DATA_CAP = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  PTR_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [MPW-1:0] META_CAP = {1'b1, {META_DEPTH_WIDTH{1'b0}}};
  localparam logic [MPW-1:0] MPTR_ONE = {{META_DEPTH_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  // Each RAM word is {last, data}. Each meta entry is {port, length}.
  logic [DATA_WIDTH:0] data_mem [2**DEPTH_WIDTH];
  logic [31:0]         meta_mem [2**META_DEPTH_WIDTH];

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       wr_commit_q, wr_commit_d;
  logic [PW-1:0]       commit_d1_q;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [MPW-1:0]      meta_wr_q, meta_wr_d;
  logic [MPW-1:0]      meta_rd_q, meta_rd_d;
  logic [15:0]         cap_port_q, cap_port_d;
  logic [15:0]         cap_len_q, cap_len_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0] out_word_q, out_word_d;
  logic                drop_pulse_q, drop_pulse_d;

  logic                mem_we, commit, data_full, meta_full, xfer, avail;
  logic [15:0]         port_adj;
  logic [31:0]         meta_wdata, meta_head;
  logic [PW-1:0]       fetch_ptr;
  logic [MPW-1:0]      meta_used;

  // The payload bits above DATA_WIDTH are intentionally discarded.
  logic unused_src_bits;
  assign unused_src_bits = ^udp_source_data;

  assign meta_used = meta_wr_q - meta_rd_q;
  assign data_full = (wr_ptr_q - rd_ptr_q) == DATA_CAP;
  assign meta_full = meta_used == META_CAP;
  assign port_adj  = udp_source_dst_port - PORT_OFFSET;

  // Write FSM. wr_ptr runs ahead speculatively. Only wr_commit is visible
  // to the read side, so a dropped packet never leaks out.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    cap_port_d   = cap_port_q;
    cap_len_d    = cap_len_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    drop_pulse_d = 1'b0;
    if (udp_source_valid) begin
      case (state_q)
        S_IDLE: begin
          cap_port_d = port_adj;
          cap_len_d  = udp_source_length;
          if (data_full || meta_full) begin
            if (udp_source_last) drop_pulse_d = 1'b1;
            else                 state_d      = S_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (udp_source_last) commit  = 1'b1;
            else                 state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (data_full) begin
            // Rewind past the partial packet.
            wr_ptr_d = wr_commit_q;
            if (udp_source_last) begin
              drop_pulse_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (udp_source_last) begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (udp_source_last) begin
            drop_pulse_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (commit) wr_commit_d = wr_ptr_q + PTR_ONE;
  end

  // A single-word packet commits in IDLE before the capture registers load.
  assign meta_wdata = (state_q == S_IDLE) ? {port_adj, udp_source_length}
                                          : {cap_port_q, cap_len_q};

  // Read side. rd_ptr advances on a sink transfer. The output register
  // prefetches the word after the one it holds. The read side compares
  // against a one-cycle-delayed wr_commit, so a committed packet first
  // appears two edges after its commit edge. Committed data always has a
  // meta entry behind it, so data availability alone gates the sink.
  assign xfer      = out_valid_q && udp_sink_ready;
  assign fetch_ptr = rd_ptr_q + (out_valid_q ? PTR_ONE : '0);
  assign avail     = fetch_ptr != commit_d1_q;

  always_comb begin
    rd_ptr_d    = xfer ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (!out_valid_q || xfer) begin
      out_valid_d = avail;
      if (avail) out_word_d = data_mem[fetch_ptr[DEPTH_WIDTH-1:0]];
    end
    meta_wr_d = commit ? meta_wr_q + MPTR_ONE : meta_wr_q;
    meta_rd_d = (xfer && out_word_q[DATA_WIDTH]) ? meta_rd_q + MPTR_ONE : meta_rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      commit_d1_q  <= '0;
      rd_ptr_q     <= '0;
      meta_wr_q    <= '0;
      meta_rd_q    <= '0;
      cap_port_q   <= '0;
      cap_len_q    <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      commit_d1_q  <= wr_commit_q;
      rd_ptr_q     <= rd_ptr_d;
      meta_wr_q    <= meta_wr_d;
      meta_rd_q    <= meta_rd_d;
      cap_port_q   <= cap_port_d;
      cap_len_q    <= cap_len_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) data_mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <=
      {udp_source_last, udp_source_data[DATA_WIDTH-1:0]};
    if (rst && commit) meta_mem[meta_wr_q[META_DEPTH_WIDTH-1:0]] <= meta_wdata;
  end

  assign meta_head         = meta_mem[meta_rd_q[META_DEPTH_WIDTH-1:0]];
  assign udp_sink_valid    = out_valid_q;
  assign udp_sink_last     = out_valid_q & out_word_q[DATA_WIDTH];
  assign udp_sink_data     = out_valid_q ? 32'(out_word_q[DATA_WIDTH-1:0]) : 32'd0;
  assign udp_sink_dst_port = out_valid_q ? meta_head[31:16] : 16'd0;
  assign udp_sink_length   = out_valid_q ? meta_head[15:0] : 16'd0;
  assign pkt_count         = meta_used;
  assign drop_pulse        = drop_pulse_q;

`ifdef UDP_BUF_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_pulse_d && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst) drop_count_q <= '0;
    else      drop_count_q <= drop_count_d;
  end
  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_udp_packet_buffer.sv
module tb_udp_packet_buffer;
  localparam int          DW     = 8;
  localparam int          DEPTH  = 16;
  localparam int          META   = 16;
  localparam logic [15:0] OFFSET = 16'h0100;
  localparam int          EW     = 65;  // {last, port, length, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        src_valid = 1'b0, src_last = 1'b0;
  logic [15:0] src_port = '0, src_len = '0;
  logic [31:0] src_data = '0;
  logic        sink_ready = 1'b1;
  logic        sink_valid, sink_last, drop_pulse;
  logic [15:0] sink_port, sink_len, drop_count;
  logic [31:0] sink_data;
  logic [4:0]  pkt_count;

  udp_packet_buffer #(.DATA_WIDTH(DW), .DEPTH_WIDTH(4), .META_DEPTH_WIDTH(4),
                      .PORT_OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst),
    .udp_source_valid(src_valid), .udp_source_last(src_last),
    .udp_source_dst_port(src_port), .udp_source_length(src_len),
    .udp_source_data(src_data),
    .udp_sink_ready(sink_ready), .udp_sink_valid(sink_valid),
    .udp_sink_last(sink_last), .udp_sink_dst_port(sink_port),
    .udp_sink_length(sink_len), .udp_sink_data(sink_data),
    .pkt_count(pkt_count), .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packets are whole queue entries. A word joins exp_q when its packet
  // commits and becomes visible two edges after that commit edge.
  logic [EW-1:0] exp_q[$];
  int            vis_q[$];
  logic [EW-1:0] cur_q[$];
  bit            dropping;
  int            m_pkts;
  logic          m_pulse;
  logic [15:0]   m_dcount;
  int            cyc = 0;
  int            c;
  bit            full_data, full_meta, pop;
  logic [15:0]   cport, clen;
  logic [EW-1:0] w;

  always @(posedge clk) begin
    c = cyc + 1;
    if (!rst) begin
      exp_q.delete(); vis_q.delete(); cur_q.delete();
      dropping = 1'b0; m_pkts = 0; m_pulse = 1'b0; m_dcount = '0;
    end else begin
      full_data = (exp_q.size() + cur_q.size()) == DEPTH;
      full_meta = m_pkts == META;
      pop       = sink_ready && exp_q.size() > 0 && vis_q[0] <= cyc;
      m_pulse   = 1'b0;
      if (src_valid) begin
        if (dropping) begin
          if (src_last) begin dropping = 1'b0; m_pulse = 1'b1; end
        end else begin
          if (cur_q.size() == 0) begin
            cport = src_port - OFFSET;
            clen  = src_len;
          end
          if (full_data || (cur_q.size() == 0 && full_meta)) begin
            cur_q.delete();
            if (src_last) m_pulse = 1'b1;
            else          dropping = 1'b1;
          end else begin
            cur_q.push_back({src_last, cport, clen, src_data & 32'h0000_00FF});
            if (src_last) begin
              foreach (cur_q[i]) begin exp_q.push_back(cur_q[i]); vis_q.push_back(c + 2); end
              cur_q.delete();
              m_pkts++;
            end
          end
        end
      end
      if (pop) begin
        w = exp_q.pop_front();
        void'(vis_q.pop_front());
        if (w[64]) m_pkts--;
      end
`ifdef UDP_BUF_STATS_EN
      if (m_pulse && m_dcount != 16'hFFFF) m_dcount = m_dcount + 16'd1;
`endif
    end
    cyc = c;
  end

  // ---------------- scoreboard compare, every cycle ----------------
  bit            exp_valid;
  logic [EW-1:0] ew;
  always @(negedge clk) begin
    if (check_en) begin
      exp_valid = exp_q.size() > 0 && vis_q[0] <= cyc;
      ew = exp_valid ? exp_q[0] : '0;
      check("sink_valid", 32'(sink_valid), 32'(exp_valid));
      check("sink_last",  32'(sink_last),  32'(ew[64]));
      check("sink_port",  32'(sink_port),  32'(ew[63:48]));
      check("sink_len",   32'(sink_len),   32'(ew[47:32]));
      check("sink_data",  sink_data,       ew[31:0]);
      check("pkt_count",  32'(pkt_count),  32'(m_pkts));
      check("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      check("drop_count", 32'(drop_count), 32'(m_dcount));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [31:0] d, input logic l,
                            input logic [15:0] p, input logic [15:0] n);
    @(negedge clk);
    src_valid = 1'b1; src_last = l; src_data = d; src_port = p; src_len = n;
  endtask

  task automatic idle_word();
    src_valid = 1'b0; src_last = 1'b0; src_data = '0;
  endtask

  // Returns at the negedge right after the last word's (commit) edge.
  task automatic send_pkt(input int nw, input logic [31:0] base,
                          input logic [15:0] p, input logic [15:0] n);
    for (int i = 0; i < nw; i++) drive_word(base + 32'(i), (i == nw - 1), p, n);
    @(negedge clk);
    idle_word();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && !sink_valid; i++) @(negedge clk);
    check("wait_valid", 32'(sink_valid), 32'd1);
  endtask

  task automatic drain();
    sink_ready = 1'b1;
    for (int i = 0; i < 100 && pkt_count != 0; i++) @(negedge clk);
    check("drain_pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
  endtask

  logic [15:0] exp_d1;

  initial begin
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("reset_valid", 32'(sink_valid), 32'd0);
    check("reset_pkt_count", 32'(pkt_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4-word packet: appears 2 edges after commit, port 0A05-0100
    send_pkt(4, 32'd1, 16'h0A05, 16'd16);
    check("t1_pkt_after_commit", 32'(pkt_count), 32'd1);
    check("t1_not_yet_valid", 32'(sink_valid), 32'd0);
    @(negedge clk);
    check("t1_still_not_valid", 32'(sink_valid), 32'd0);
    @(negedge clk);
    check("t1_first_valid", 32'(sink_valid), 32'd1);
    check("t1_first_data", sink_data, 32'd1);
    check("t1_port", 32'(sink_port), 32'h0905);
    check("t1_len", 32'(sink_len), 32'd16);
    repeat (3) @(negedge clk);
    check("t1_word4", sink_data, 32'd4);
    check("t1_last", 32'(sink_last), 32'd1);
    @(negedge clk);
    check("t1_pkt_done", 32'(pkt_count), 32'd0);
    drain();

    // Single-word packet, upper data bits truncated
    send_pkt(1, 32'hABCDEF12, 16'h1234, 16'd9);
    repeat (2) @(negedge clk);
    check("t2_data", sink_data, 32'h0000_0012);
    check("t2_last", 32'(sink_last), 32'd1);
    check("t2_port", 32'(sink_port), 32'h1134);
    drain();

    // 20 words into a 16-word RAM: dropped atomically
    send_pkt(20, 32'h20, 16'h2000, 16'd40);
    check("t3_drop_pulse", 32'(drop_pulse), 32'd1);
    check("t3_no_valid", 32'(sink_valid), 32'd0);
`ifdef UDP_BUF_STATS_EN
    exp_d1 = 16'd1;
`else
    exp_d1 = 16'd0;
`endif
    check("t3_drop_count", 32'(drop_count), 32'(exp_d1));
    @(negedge clk);
    check("t3_pulse_one_cycle", 32'(drop_pulse), 32'd0);
    send_pkt(3, 32'h41, 16'h0105, 16'd6);
    wait_valid();
    check("t3_next_data", sink_data, 32'h41);
    check("t3_next_port", 32'(sink_port), 32'h0005);
    drain();

    // Meta FIFO full: 16 held, 17th dropped
    sink_ready = 1'b0;
    for (int k = 0; k < 17; k++) drive_word(32'h30 + 32'(k), 1'b1, 16'h0300 + 16'(k), 16'(k + 1));
    @(negedge clk);
    idle_word();
    check("t4_pkt_count_full", 32'(pkt_count), 32'd16);
    check("t4_drop_pulse", 32'(drop_pulse), 32'd1);
    @(negedge clk);
    check("t4_head_data", sink_data, 32'h30);
    check("t4_head_port", 32'(sink_port), 32'h0200);
    drain();

    // Commit of B on the same edge that A's last word is read
    send_pkt(3, 32'h51, 16'h0500, 16'd6);
    idle_word();
    repeat (2) @(negedge clk);
    send_pkt(2, 32'h61, 16'h0600, 16'd4);
    check("t5_pkt_steady", 32'(pkt_count), 32'd1);
    wait_valid();
    check("t5_b_data", sink_data, 32'h61);
    check("t5_b_port", 32'(sink_port), 32'h0500);
    check("t5_b_len", 32'(sink_len), 32'd4);
    drain();

    // Reset with a queued packet and a partial packet in flight
    sink_ready = 1'b0;
    send_pkt(1, 32'h71, 16'h0700, 16'd2);
    drive_word(32'h72, 1'b0, 16'h0800, 16'd8);
    drive_word(32'h73, 1'b0, 16'h0800, 16'd8);
    @(negedge clk);
    idle_word();
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_valid", 32'(sink_valid), 32'd0);
    check("t6_reset_pkt_count", 32'(pkt_count), 32'd0);
    rst = 1'b1;
    send_pkt(2, 32'h81, 16'h0900, 16'd4);
    sink_ready = 1'b1;
    wait_valid();
    check("t6_post_data", sink_data, 32'h81);
    check("t6_post_port", 32'(sink_port), 32'h0800);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/udp_packet_buffer.md
Name: udp_packet_buffer

Overview:
- Store-and-forward successor to the byte-wide UDP buffer: sits between the UDP RX core and the LED frame writer.
- Accepts UDP payload words with no backpressure, holds each packet until its last word arrives, then presents it whole on a FWFT sink.
- Adds a parametrised data width, depth and port offset, plus per-packet metadata and atomic drop of packets that do not fit.

Parameters:
- DATA_WIDTH, 8, payload bits kept per word (1..32); upper sink data bits driven 0.
- DEPTH_WIDTH, 10, data RAM holds 2^DEPTH_WIDTH words.
- META_DEPTH_WIDTH, 4, up to 2^META_DEPTH_WIDTH committed packets queued.
- PORT_OFFSET, 16'h0100, subtracted mod 2^16 from dst_port before forwarding.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-low.
- udp_source_valid  in  1  word strobe; no ready, source never stalls.
- udp_source_last  in  1  final word of packet.
- udp_source_dst_port  in  16  destination port; sampled on first word.
- udp_source_length  in  16  UDP length; sampled on first word.
- udp_source_data  in  32  payload; bits [DATA_WIDTH-1:0] stored.
- udp_sink_ready  in  1  consumer accepts current word.
- udp_sink_valid  out  1  word available.
- udp_sink_last  out  1  final word of packet.
- udp_sink_dst_port  out  16  captured port minus PORT_OFFSET.
- udp_sink_length  out  16  captured length.
- udp_sink_data  out  32  zero-extended payload.
- pkt_count  out  META_DEPTH_WIDTH+1  committed packets not yet fully read.
- drop_pulse  out  1  one-cycle pulse per dropped packet.
- drop_count  out  16  saturating drop counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at clk edge): all pointers, pkt_count, write FSM cleared; all outputs 0 the following cycle; partial packet discarded.
- Pointers DEPTH_WIDTH+1 bits: wr_ptr (speculative), wr_commit, rd_ptr. Data full: wr_ptr-rd_ptr == 2^DEPTH_WIDTH. RAM word = {last, data}.
- Write FSM IDLE/RECV/DROP:
  - IDLE, valid: capture port-PORT_OFFSET and length. If data full or meta full -> DROP (or stay IDLE with drop_pulse if last). Else write word; last -> commit, stay IDLE; else -> RECV.
  - RECV, valid: data full -> wr_ptr:=wr_commit, -> DROP (if last, pulse drop, -> IDLE). Else write; on last commit, -> IDLE.
  - DROP: ignore words; on valid&last pulse drop_pulse, -> IDLE.
- Commit: wr_commit:=wr_ptr+1 (including the last word), push {port,length} into meta FIFO, pkt_count+1.
- Packets longer than 2^DEPTH_WIDTH words are always dropped; no partial packet is ever visible on sink.
- Read side: FWFT. udp_sink_valid=1 when rd_ptr!=wr_commit and meta non-empty; first word of a committed packet is valid 2 cycles after the commit edge. Transfer on valid&ready; one word per cycle sustained.
- dst_port/length come from meta head and are constant over the packet; meta popped and pkt_count-1 on transfer of a last word.
- All sink outputs are 0 while udp_sink_valid=0.
- Commit and last-word pop in the same cycle: pkt_count unchanged, both meta operations happen.
- Pointer wrap: modulo 2^(DEPTH_WIDTH+1); behaviour identical across wrap.

Optional Feature:
- Macro UDP_BUF_STATS_EN.
- Defined: drop_count increments on every drop_pulse, saturates at 16'hFFFF, cleared only by reset.
- Undefined: drop_count tied to 0, no counter logic; drop_pulse still present.

Test Plan:
- 4-word packet, port 16'h0A05, length 16, data 1..4 -> sink valid 2 cycles after last; words 1..4, last on 4th, port 16'h0905, length 16; pkt_count 1->0.
- Single-word packet (valid&last in IDLE), data 0xABCDEF12, DATA_WIDTH=8 -> sink data 0x00000012, last=1.
- DEPTH_WIDTH=4, 20-word packet -> drop_pulse once at last word, no sink valid, drop_count=1 (macro on) / 0 (off); next 3-word packet delivered intact.
- Sink ready low; send META_DEPTH+1 single-word packets -> first 16 held, pkt_count=16, 17th dropped; release ready -> 16 words in order.
- Commit of packet B in same cycle as last word of A read -> pkt_count steady at 1, B follows A with correct metadata.
- rst=0 mid-packet and with queued data -> next cycle sink_valid=0, pkt_count=0; post-reset packet delivered normally.
